// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CSUM, S_FINISH} state_t;

    localparam int INSTR_W        = 32;
    localparam int BYTES_PER_WORD = 4;

    // Limit a requested word count to what the memory can hold.
    function automatic logic [31:0] clip_count(input logic [31:0] cnt, input logic [31:0] cap);
        return (cnt > cap) ? cap : cnt;
    endfunction
endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, instruction-memory write port out. master = loader side.
interface imem_loader_if #(parameter int ADDR_W = 10);
    import imem_loader_pkg::*;

    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_wdata;

    modport master (input rx_data, rx_valid, output rx_ready, mem_we, mem_addr, mem_wdata);
    modport slave  (output rx_data, rx_valid, input rx_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_word_packer.sv
// Shifts bytes MSB-first into a 32-bit word; word_full marks the byte that completes it.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               clr,
    input  logic               shift,
    input  logic [7:0]         din,
    output logic [INSTR_W-1:0] word,
    output logic               word_full
);
    logic [1:0] idx;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            word <= '0;
            idx  <= '0;
        end else if (clr) begin
            word <= '0;
            idx  <= '0;
        end else if (shift) begin
            word <= {word[INSTR_W-9:0], din};
            idx  <= idx + 2'd1;
        end
    end

    assign word_full = shift && (idx == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/imem_loader.sv
// Packs a byte stream into big-endian words and writes them to instruction memory,
// holding the CPU until the image is loaded. IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int COUNT_W = 9
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               start,
    input  logic [COUNT_W-1:0] word_count,
    imem_loader_if.master      bus,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int          REM_W = ADDR_W - 1;
    localparam logic [31:0] CAP   = 32'(1) << (ADDR_W - 2);

    state_t               state, state_nx, after_img;
    logic [REM_W-1:0]     remaining, start_rem;
    logic [ADDR_W-1:0]    waddr;
    logic [INSTR_W-1:0]   word;
    logic                 hold_q, start_ok, accept, shift, word_full;

    assign start_ok  = (state == S_IDLE) && start;
    assign accept    = bus.rx_valid && bus.rx_ready;
    assign shift     = accept && (state == S_RECV);
    assign start_rem = REM_W'(clip_count(32'(word_count), CAP));

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign after_img = S_CSUM;
`else
    assign after_img = S_FINISH;
`endif

    imem_word_packer u_packer (
        .CLK       (CLK),
        .RESET     (RESET),
        .clr       (start_ok),
        .shift     (shift),
        .din       (bus.rx_data),
        .word      (word),
        .word_full (word_full)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (start) state_nx = (start_rem != '0) ? S_RECV : after_img;
            S_RECV:   if (word_full) state_nx = S_WRITE;
            S_WRITE:  state_nx = (remaining != REM_W'(1)) ? S_RECV : after_img;
            S_CSUM:   if (accept) state_nx = S_FINISH;
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= S_IDLE;
            remaining <= '0;
            waddr     <= '0;
            hold_q    <= 1'b1;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                remaining <= start_rem;
                waddr     <= '0;
            end else if (state == S_WRITE) begin
                remaining <= remaining - REM_W'(1);
                waddr     <= waddr + ADDR_W'(4);
            end
            // Release the CPU on the same edge that enters FINISH so it drops with done.
            if (state_nx == S_FINISH) hold_q <= 1'b0;
            else if (start_ok)        hold_q <= 1'b1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum, csum_chk;
    logic       err_q;

    assign csum_chk = csum + bus.rx_data;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            csum  <= '0;
            err_q <= 1'b0;
        end else if (start_ok) begin
            csum  <= '0;
            err_q <= 1'b0;
        end else if (shift) begin
            csum  <= csum_chk;
        end else if (accept && state == S_CSUM) begin
            err_q <= (csum_chk != 8'd0);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign bus.rx_ready  = (state == S_RECV) || (state == S_CSUM);
    assign bus.mem_we    = (state == S_WRITE);
    assign bus.mem_addr  = waddr;
    assign bus.mem_wdata = word;
    assign busy          = (state == S_RECV) || (state == S_WRITE) || (state == S_CSUM);
    assign done          = (state == S_FINISH);
    assign cpu_hold      = hold_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a word-level model of the image predicts every memory write.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int ADDR_W  = 10;
    localparam int COUNT_W = 9;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int DONE_LAT = 2;
`else
    localparam int DONE_LAT = 1;
`endif

    typedef logic [7:0] bq_t[$];

    logic               CLK = 1'b0;
    logic               RESET = 1'b0;
    logic               start = 1'b0;
    logic [COUNT_W-1:0] word_count = '0;
    logic               cpu_hold, busy, done, err;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus();

    imem_loader #(.ADDR_W(ADDR_W), .COUNT_W(COUNT_W)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .start      (start),
        .word_count (word_count),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 CLK = ~CLK;

    int checks = 0, failures = 0;
    int cyc = 0, last_we_cyc = -100, wr_cnt = 0;
    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] exp_a[$];
    logic [31:0]       wr_log[$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endfunction

    always @(posedge CLK) cyc++;

    // Every write must be the next word of the image at address 4*i; invariants every cycle.
    always @(negedge CLK) begin
        if (RESET) begin
            if (bus.mem_we) begin
                wr_cnt++;
                last_we_cyc = cyc;
                wr_log.push_back(bus.mem_wdata);
                chk("write_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk("wr_data", bus.mem_wdata, exp_q.pop_front());
                    chk("wr_addr", 32'(bus.mem_addr), 32'(exp_a.pop_front()));
                end
                chk("ready_in_write", 32'(bus.rx_ready), 0);
            end
            if (done) begin
                chk("hold_at_done", 32'(cpu_hold), 0);
                chk("busy_at_done", 32'(busy), 0);
            end
            if (busy) chk("hold_while_busy", 32'(cpu_hold), 1);
        end
    end

    task automatic model_load(input int cnt, input bq_t img);
        for (int w = 0; w < cnt; w++) begin
            exp_q.push_back(32'(img[4*w]) * 32'h0100_0000 + 32'(img[4*w+1]) * 32'h0001_0000 +
                            32'(img[4*w+2]) * 32'h0000_0100 + 32'(img[4*w+3]));
            exp_a.push_back(ADDR_W'(4 * w));
        end
    endtask

    function automatic bq_t with_csum(input bq_t img);
        bq_t s = img;
`ifdef IMEM_LOADER_CHECKSUM_EN
        int sum = 0;
        foreach (img[i]) sum += int'(img[i]);
        s.push_back(8'((256 - sum % 256) % 256));
`endif
        return s;
    endfunction

    task automatic pulse_start(input int n);
        @(negedge CLK);
        start = 1'b1;
        word_count = COUNT_W'(n);
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Called at a negedge; rx_ready is stable until the next posedge, so fire is exact.
    task automatic send_bytes(input bq_t s, input bit rnd);
        int i = 0, k = 0;
        bit fire;
        while (i < s.size() && k < 500) begin
            bus.rx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.rx_data  = s[i];
            fire = bus.rx_valid && bus.rx_ready;
            @(negedge CLK);
            if (fire) i++;
            k++;
        end
        bus.rx_valid = 1'b0;
        chk("bytes_sent", 32'(i), 32'(s.size()));
    endtask

    task automatic wait_done(output int t);
        int k = 0;
        while (!done && k < 200) begin
            @(negedge CLK);
            k++;
        end
        chk("done_seen", 32'(done), 1);
        t = cyc;
    endtask

    initial begin
        bq_t img, s, part;
        int  t, w0;

        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        #12;
        chk("rst_rx_ready", 32'(bus.rx_ready), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cpu_hold", 32'(cpu_hold), 1);
        @(negedge CLK);
        RESET = 1'b1;

        // Two-word load, rx_valid constantly high
        img = '{8'h00, 8'h01, 8'h10, 8'h20, 8'h00, 8'h64, 8'h28, 8'h24};
        wr_log.delete();
        w0 = wr_cnt;
        model_load(2, img);
        chk("model_w0", exp_q[0], 32'h0001_1020);
        chk("model_w1", exp_q[1], 32'h0064_2824);
        pulse_start(2);
        chk("busy_after_start", 32'(busy), 1);
        chk("ready_after_start", 32'(bus.rx_ready), 1);
        chk("hold_after_start", 32'(cpu_hold), 1);
        send_bytes(with_csum(img), 1'b0);
        wait_done(t);
        chk("writes_2w", 32'(wr_cnt - w0), 2);
        chk("done_latency", 32'(t - last_we_cyc), 32'(DONE_LAT));
        chk("log_w0", wr_log[0], 32'h0001_1020);
        chk("log_w1", wr_log[1], 32'h0064_2824);
        chk("err_clean", 32'(err), 0);
        @(negedge CLK);
        chk("done_one_cycle", 32'(done), 0);
        chk("hold_released", 32'(cpu_hold), 0);

        // Same image with a stalling source
        wr_log.delete();
        w0 = wr_cnt;
        model_load(2, img);
        pulse_start(2);
        send_bytes(with_csum(img), 1'b1);
        wait_done(t);
        chk("writes_rand", 32'(wr_cnt - w0), 2);
        chk("log_rand_w0", wr_log[0], 32'h0001_1020);
        chk("log_rand_w1", wr_log[1], 32'h0064_2824);
        chk("queue_drained_rand", 32'(exp_q.size()), 0);

        // Zero-word load
        w0 = wr_cnt;
        pulse_start(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("zero_csum_ready", 32'(bus.rx_ready), 1);
        chk("zero_no_done_yet", 32'(done), 0);
        s = '{8'h00};
        send_bytes(s, 1'b0);
        wait_done(t);
`else
        chk("zero_done_next", 32'(done), 1);
`endif
        chk("zero_no_write", 32'(wr_cnt - w0), 0);
        @(negedge CLK);

        // Reset after 6 bytes of a 3-word load
        img = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
        w0 = wr_cnt;
        model_load(3, img);
        pulse_start(3);
        part.delete();
        for (int i = 0; i < 6; i++) part.push_back(img[i]);
        send_bytes(part, 1'b0);
        #2 RESET = 1'b0;
        #1;
        chk("midrst_one_write", 32'(wr_cnt - w0), 1);
        chk("midrst_rx_ready", 32'(bus.rx_ready), 0);
        chk("midrst_mem_we", 32'(bus.mem_we), 0);
        chk("midrst_mem_addr", 32'(bus.mem_addr), 0);
        chk("midrst_mem_wdata", bus.mem_wdata, 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_hold", 32'(cpu_hold), 1);
        exp_q.delete();
        exp_a.delete();
        @(negedge CLK);
        RESET = 1'b1;
        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        w0 = wr_cnt;
        model_load(1, img);
        pulse_start(1);
        send_bytes(with_csum(img), 1'b0);
        wait_done(t);
        chk("reload_writes", 32'(wr_cnt - w0), 1);

        // start pulsed mid-RECV must be ignored
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        s = with_csum(img);
        w0 = wr_cnt;
        model_load(2, img);
        pulse_start(2);
        part.delete();
        for (int i = 0; i < 2; i++) part.push_back(s[i]);
        send_bytes(part, 1'b0);
        start = 1'b1;
        word_count = COUNT_W'(5);
        @(negedge CLK);
        start = 1'b0;
        chk("start_ignored_busy", 32'(busy), 1);
        part.delete();
        for (int i = 2; i < s.size(); i++) part.push_back(s[i]);
        send_bytes(part, 1'b0);
        wait_done(t);
        chk("start_ignored_writes", 32'(wr_cnt - w0), 2);
        chk("queue_drained_ign", 32'(exp_q.size()), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum good then bad
        img = '{8'h01, 8'h02, 8'h03, 8'h04};
        model_load(1, img);
        pulse_start(1);
        s = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
        send_bytes(s, 1'b0);
        wait_done(t);
        chk("csum_good_err", 32'(err), 32'((8'(10 + 8'hF6)) != 8'd0));
        chk("csum_good_lit", 32'(err), 0);
        model_load(1, img);
        pulse_start(1);
        s = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF7};
        send_bytes(s, 1'b0);
        wait_done(t);
        chk("csum_bad_lit", 32'(err), 1);
        repeat (3) begin
            @(negedge CLK);
            chk("err_sticky", 32'(err), 1);
        end
        pulse_start(0);
        chk("err_cleared_on_start", 32'(err), 0);
        s = '{8'h00};
        send_bytes(s, 1'b0);
        wait_done(t);
`endif

        repeat (2) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
